// File: rtl/xeng_pkg.sv
// rtl/xeng_pkg.sv - shared X-engine widths, Stokes constants and component packing helpers
package xeng_pkg;

    localparam int N_STOKES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vacc_state_t;

    function automatic int n_stokes(input int n_pols);
        return n_pols * n_pols;
    endfunction

    function automatic int w_in(input int bitwidth, input int p_factor_bits, input int serial_acc_len_bits);
        return 2 * bitwidth + 1 + p_factor_bits + serial_acc_len_bits;
    endfunction

    function automatic int acc_width(input int stokes, input int comp_w);
        return stokes * 2 * comp_w;
    endfunction

    // Bit offset of one component: Stokes-major, real in the upper half of each Stokes pair.
    function automatic int comp_lsb(input int stokes, input int is_real, input int comp_w);
        return (2 * stokes + is_real) * comp_w;
    endfunction

endpackage

// File: rtl/vacc_sdp_ram.sv
// rtl/vacc_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module vacc_sdp_ram #(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/xeng_vacc.sv
// rtl/xeng_vacc.sv - X-engine vector accumulator; XENG_VACC_SATURATE_EN selects clamping sums
module xeng_vacc
    import xeng_pkg::*;
#(
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int P_FACTOR_BITS       = 2,
    parameter int BITWIDTH            = 4,
    parameter int N_POLS              = 2,
    parameter int VECTOR_LEN_BITS     = 8,
    parameter int OUT_WIDTH           = 32,
    parameter int ACC_LEN_BITS        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    input  logic [acc_width(N_POLS*N_POLS, w_in(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS))-1:0] acc_in,
    input  logic valid_in,
    input  logic [ACC_LEN_BITS-1:0] acc_len,
    output logic [N_POLS*N_POLS*2*OUT_WIDTH-1:0] dout,
    output logic dout_valid,
    output logic dout_sync,
    output logic overflow
);

    localparam int N_ST      = n_stokes(N_POLS);
    localparam int W_IN      = w_in(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
    localparam int ACC_WIDTH = acc_width(N_ST, W_IN);
    localparam int OUT_BUS   = N_ST * 2 * OUT_WIDTH;
    localparam int N_COMP    = 2 * N_ST;

    vacc_state_t                r_state;
    logic [VECTOR_LEN_BITS-1:0] r_addr;
    logic [ACC_LEN_BITS-1:0]    r_vec;
    logic [ACC_LEN_BITS-1:0]    r_len;

    logic [ACC_LEN_BITS-1:0]    w_acc_len_eff;
    logic [VECTOR_LEN_BITS-1:0] w_addr;
    logic [ACC_LEN_BITS-1:0]    w_vec;
    logic [ACC_LEN_BITS-1:0]    w_len;
    logic                       w_accept;
    logic                       w_vec_last;

    // sync_in overrides the counters combinationally so a coincident word lands at addr 0, vec 0.
    assign w_acc_len_eff = (acc_len == '0) ? ACC_LEN_BITS'(1) : acc_len;
    assign w_addr        = sync_in ? '0 : r_addr;
    assign w_vec         = sync_in ? '0 : r_vec;
    assign w_len         = sync_in ? w_acc_len_eff : r_len;
    assign w_accept      = valid_in && (sync_in || (r_state == ST_RUN));
    assign w_vec_last    = (w_vec == (w_len - ACC_LEN_BITS'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_vec   <= '0;
            r_len   <= ACC_LEN_BITS'(1);
        end else begin
            if (sync_in) begin
                r_state <= ST_RUN;
            end
            r_addr <= w_addr;
            r_vec  <= w_vec;
            r_len  <= w_len;
            if (w_accept) begin
                r_addr <= w_addr + VECTOR_LEN_BITS'(1);
                if (&w_addr) begin
                    if (w_vec_last) begin
                        r_vec <= '0;
                        r_len <= w_acc_len_eff;
                    end else begin
                        r_vec <= w_vec + ACC_LEN_BITS'(1);
                    end
                end
            end
        end
    end

    logic                       r1_valid;
    logic [VECTOR_LEN_BITS-1:0] r1_addr;
    logic                       r1_first;
    logic                       r1_dump;
    logic                       r1_sop;
    logic [ACC_WIDTH-1:0]       r1_data;

    logic                       r2_valid;
    logic [VECTOR_LEN_BITS-1:0] r2_addr;
    logic                       r2_dump;
    logic                       r2_sop;
    logic [OUT_BUS-1:0]         r2_sum;

    logic [OUT_BUS-1:0]         w_ram_rd;
    logic [OUT_BUS-1:0]         w_sum;

    vacc_sdp_ram #(
        .WIDTH     (OUT_BUS),
        .ADDR_BITS (VECTOR_LEN_BITS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (r2_valid),
        .i_wr_addr (r2_addr),
        .i_wr_data (r2_sum),
        .i_rd_addr (w_addr),
        .o_rd_data (w_ram_rd)
    );

`ifdef XENG_VACC_SATURATE_EN
    logic [N_COMP-1:0] w_clip;
`endif

    for (genvar k = 0; k < N_COMP; k++) begin : g_comp
        localparam int LSB_IN  = comp_lsb(k / 2, k % 2, W_IN);
        localparam int LSB_OUT = comp_lsb(k / 2, k % 2, OUT_WIDTH);

        logic signed [W_IN-1:0]      w_raw;
        logic signed [OUT_WIDTH-1:0] w_ext;
        logic [OUT_WIDTH-1:0]        w_old;

        assign w_raw = r1_data[LSB_IN +: W_IN];
        assign w_ext = OUT_WIDTH'(w_raw);
        // The first vector overwrites, so stale RAM contents never need clearing.
        assign w_old = r1_first ? '0 : w_ram_rd[LSB_OUT +: OUT_WIDTH];

`ifdef XENG_VACC_SATURATE_EN
        logic [OUT_WIDTH:0] w_full;
        assign w_full    = {w_old[OUT_WIDTH-1], w_old} + {w_ext[OUT_WIDTH-1], w_ext};
        assign w_clip[k] = (w_full[OUT_WIDTH] != w_full[OUT_WIDTH-1]);
        assign w_sum[LSB_OUT +: OUT_WIDTH] = !w_clip[k] ? w_full[OUT_WIDTH-1:0] :
            (w_full[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}});
`else
        assign w_sum[LSB_OUT +: OUT_WIDTH] = w_old + w_ext;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid   <= 1'b0;
            r1_addr    <= '0;
            r1_first   <= 1'b0;
            r1_dump    <= 1'b0;
            r1_sop     <= 1'b0;
            r1_data    <= '0;
            r2_valid   <= 1'b0;
            r2_addr    <= '0;
            r2_dump    <= 1'b0;
            r2_sop     <= 1'b0;
            r2_sum     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sync  <= 1'b0;
        end else begin
            r1_valid   <= w_accept;
            r1_addr    <= w_addr;
            r1_first   <= (w_vec == '0);
            r1_dump    <= w_vec_last;
            r1_sop     <= w_vec_last && (w_addr == '0);
            r1_data    <= acc_in;
            r2_valid   <= r1_valid;
            r2_addr    <= r1_addr;
            r2_dump    <= r1_valid && r1_dump;
            r2_sop     <= r1_valid && r1_sop;
            r2_sum     <= w_sum;
            dout_valid <= r2_valid && r2_dump;
            dout_sync  <= r2_valid && r2_sop;
            if (r2_valid && r2_dump) begin
                dout <= r2_sum;
            end
        end
    end

`ifdef XENG_VACC_SATURATE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (r1_valid && (|w_clip)) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_xeng_vacc.sv
// tb/tb_xeng_vacc.sv - directed self-checking bench for xeng_vacc (wide and 20-bit output instances)
module tb_xeng_vacc;

    localparam int ACC_W = 144;
    localparam int OUT_A = 256;
    localparam int OUT_B = 160;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             sync_a, valid_a, sync_b, valid_b;
    logic [ACC_W-1:0] acc_a, acc_b;
    logic [15:0]      acc_len_a, acc_len_b;
    logic [OUT_A-1:0] dout_a;
    logic [OUT_B-1:0] dout_b;
    logic             dout_valid_a, dout_sync_a, overflow_a;
    logic             dout_valid_b, dout_sync_b, overflow_b;

    xeng_vacc #(.VECTOR_LEN_BITS(2), .OUT_WIDTH(32)) u_dut_a (
        .clk(clk), .rst(rst), .sync_in(sync_a), .acc_in(acc_a), .valid_in(valid_a),
        .acc_len(acc_len_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .dout_sync(dout_sync_a), .overflow(overflow_a)
    );

    xeng_vacc #(.VECTOR_LEN_BITS(2), .OUT_WIDTH(20)) u_dut_b (
        .clk(clk), .rst(rst), .sync_in(sync_b), .acc_in(acc_b), .valid_in(valid_b),
        .acc_len(acc_len_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .dout_sync(dout_sync_b), .overflow(overflow_b)
    );

    typedef struct {
        int               c;
        logic             s;
        logic [OUT_A-1:0] d;
    } ev_t;

    ev_t              qa[$];
    int               nb = 0;
    logic [OUT_B-1:0] last_b = '0;

    always @(negedge clk) begin
        if (dout_valid_a) qa.push_back('{cyc, dout_sync_a, dout_a});
        if (dout_valid_b) begin
            nb     <= nb + 1;
            last_b <= dout_b;
        end
    end

    int total = 0;
    int bad   = 0;
    int last_drv;
    int dc[12];

    function automatic logic [ACC_W-1:0] fill18(input int val);
        logic [ACC_W-1:0] f;
        for (int k = 0; k < 8; k++) f[k*18 +: 18] = val[17:0];
        return f;
    endfunction

    function automatic logic [OUT_A-1:0] fill32(input int val);
        logic [OUT_A-1:0] f;
        for (int k = 0; k < 8; k++) f[k*32 +: 32] = val;
        return f;
    endfunction

    function automatic logic [OUT_B-1:0] fill20(input int val);
        logic [OUT_B-1:0] f;
        for (int k = 0; k < 8; k++) f[k*20 +: 20] = val[19:0];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [OUT_A-1:0] obs, input logic [OUT_A-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic s, input logic v, input int val);
        @(negedge clk);
        sync_a   = s;
        valid_a  = v;
        acc_a    = fill18(val);
        last_drv = cyc;
    endtask

    task automatic drv_b(input logic s, input logic v, input int val);
        @(negedge clk);
        sync_b = s;
        valid_b = v;
        acc_b = fill18(val);
    endtask

    task automatic check_dump(input string tag, input int n, input int val);
        chk({tag, "_count"}, qa.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < qa.size()) begin
                chk({tag, "_data"}, qa[i].d, fill32(val));
                chk({tag, "_sync"}, qa[i].s, (i == 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        sync_a = 0; valid_a = 0; acc_a = '0; acc_len_a = 16'd3;
        sync_b = 0; valid_b = 0; acc_b = '0; acc_len_b = 16'd16;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_dout", dout_a, '0);
        chk("rst_dout_valid", dout_valid_a, 0);
        chk("rst_dout_sync", dout_sync_a, 0);
        chk("rst_overflow_a", overflow_a, 0);
        chk("rst_overflow_b", overflow_b, 0);

        // IDLE: words without a prior sync are dropped
        for (int i = 0; i < 6; i++) drv_a(0, 1, 9);
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        chk("idle_ignore", qa.size(), 0);

        // back-to-back, acc_len=3, value 5
        qa.delete();
        acc_len_a = 16'd3;
        for (int i = 0; i < 12; i++) begin
            drv_a(i == 0, 1, 5);
            dc[i] = last_drv;
        end
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        check_dump("b2b", 4, 15);
        if (qa.size() > 0) chk("b2b_latency", qa[0].c, dc[8] + 3);

        // acc_len=0 behaves as 1: pass-through of -3
        qa.delete();
        acc_len_a = 16'd0;
        for (int i = 0; i < 4; i++) begin
            drv_a(i == 0, 1, -3);
            dc[i] = last_drv;
        end
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        check_dump("len0", 4, -3);
        if (qa.size() > 0) chk("len0_raw", qa[0].d[31:0], 32'hFFFF_FFFD);
        if (qa.size() > 3) chk("len0_latency", qa[3].c, dc[3] + 3);

        // partial integration abandoned by a new sync
        qa.delete();
        acc_len_a = 16'd3;
        for (int i = 0; i < 6; i++) drv_a(i == 0, 1, 7);
        for (int i = 0; i < 12; i++) drv_a(i == 0, 1, 1);
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        check_dump("resync", 4, 3);

        // valid_in toggling 1/0
        qa.delete();
        for (int i = 0; i < 12; i++) begin
            drv_a(i == 0, 1, 5);
            dc[i] = last_drv;
            drv_a(0, 0, 0);
        end
        repeat (6) @(negedge clk);
        check_dump("gaps", 4, 15);
        for (int i = 0; i < 4; i++) begin
            if (i < qa.size()) chk("gaps_latency", qa[i].c, dc[8 + i] + 3);
        end

        // 20-bit instance: 16 vectors of max positive input
        for (int i = 0; i < 64; i++) drv_b(i == 0, 1, 131071);
        drv_b(0, 0, 0);
        repeat (6) @(negedge clk);
        chk("long_count", nb, 4);
`ifdef XENG_VACC_SATURATE_EN
        chk("long_value", last_b, fill20(524287));
        chk("long_overflow", overflow_b, 1);
`else
        chk("long_value", last_b, fill20(-16));
        chk("long_overflow", overflow_b, 0);
`endif

        // reset while words are in flight
        acc_len_a = 16'd1;
        for (int i = 0; i < 3; i++) drv_a(i == 0, 1, 5);
        @(negedge clk);
        chk("pre_rst_valid", dout_valid_a, 1);
        rst = 1'b1;
        sync_a = 0;
        valid_a = 0;
        #1;
        chk("mid_rst_dout", dout_a, '0);
        chk("mid_rst_valid", dout_valid_a, 0);
        chk("mid_rst_sync", dout_sync_a, 0);
        chk("mid_rst_overflow", overflow_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        qa.delete();
        for (int i = 0; i < 8; i++) drv_a(0, 1, 5);
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        chk("post_rst_ignore", qa.size(), 0);
        for (int i = 0; i < 4; i++) drv_a(i == 0, 1, 2);
        drv_a(0, 0, 0);
        repeat (6) @(negedge clk);
        check_dump("post_rst", 4, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xeng_vacc.md
# xeng_vacc

Vector accumulator placed directly downstream of the last baseline tap in the X-engine chain. It takes the per-baseline short-term accumulation words and their valid flags from the tap shift register and sums them, per word, over a programmable number of vectors in on-chip RAM. It emits each completed long-term integration as one frame of widened, sign-extended Stokes words, marked by a frame sync.

## Interface
Parameters:
- SERIAL_ACC_LEN_BITS, 7, serial accumulation length (log2) used by the upstream taps.
- P_FACTOR_BITS, 2, parallel sample factor (log2) used by the upstream taps.
- BITWIDTH, 4, real/imag bits of each input sample.
- N_POLS, 2, polarisations; N_STOKES = N_POLS*N_POLS.
- VECTOR_LEN_BITS, 8, log2 of words per vector. Legal range is at least 2.
- OUT_WIDTH, 32, bits per real/imag output component.
- ACC_LEN_BITS, 16, width of the acc_len port.

Derived values:
- W_IN = 2*BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS, which is 18 at the defaults.
- ACC_WIDTH = N_STOKES*2*W_IN.
- OUT_BUS = N_STOKES*2*OUT_WIDTH.

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- sync_in, in, 1: marks word 0 of vector 0 of a new integration.
- acc_in, in, ACC_WIDTH: packed signed components, Stokes-major with real above imag.
- valid_in, in, 1: acc_in carries a word.
- acc_len, in, ACC_LEN_BITS: number of vectors per integration. A value of 0 is treated as 1.
- dout, out, OUT_BUS: integrated words, packed in the same order as acc_in.
- dout_valid, out, 1: dout holds a word.
- dout_sync, out, 1: dout holds word 0 of a dump.
- overflow, out, 1: sticky flag that a saturation occurred.

## Operation
- States:
  - IDLE: entered on reset; valid_in is ignored.
  - RUN: entered on the first sync_in.
  - There is no path back to IDLE except rst.
- Counters and acc_len latch:
  - addr counts valid words from 0 to 2^VECTOR_LEN_BITS-1. When it wraps, vec increments.
  - vec counts from 0 to len-1, then wraps to 0.
  - len is latched from acc_len at every sync_in and at every vec wrap to 0.
- sync_in in any state:
  - addr and vec are forced to 0 and len is relatched.
  - A word coincident with sync_in is processed as addr 0, vec 0.
  - A partial integration in progress is discarded without a dump.
- Per valid word: each component is sign-extended from W_IN to OUT_WIDTH.
  - If vec==0 (first vector), the extended input is written to RAM[addr]; the old contents are ignored.
  - Otherwise, RAM[addr] + input is written back.
- Dump: when vec==len-1, the same sum (or the input alone when len==1) is also driven on dout with dout_valid=1.
  - dout_sync=1 on addr 0 of that vector.
- Arithmetic: each component is added independently in two's complement at OUT_WIDTH.
- The RAM is never cleared; the first-vector overwrite makes clearing unnecessary.
- Gaps in valid_in are allowed. Counters advance only on valid_in.

## Timing
- Pipeline for a valid word at cycle t:
  - t: RAM read address issued.
  - t+1: RAM data available and input registered.
  - t+2: sum registered and RAM write issued.
  - t+3: dout, dout_valid and dout_sync registered.
- Latency from valid_in to dout_valid is 3 cycles, fixed.
- Read-modify-write hazard: the same address is re-read no earlier than t+2^VECTOR_LEN_BITS, which is at least t+4, after the write at t+2. No bypass is required.
- Full throughput: one word per cycle, back to back.
- Reset values: dout=0, dout_valid=0, dout_sync=0, overflow=0, state=IDLE, addr=0, vec=0, len=1.
- Reset asserted mid-operation kills all in-flight words; dout_valid is low from the next edge.

## Configuration
- XENG_VACC_SATURATE_EN defined:
  - Each component sum clamps to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
  - The clamped value is both written and output.
  - overflow sets on any clamp and stays set until rst.
- XENG_VACC_SATURATE_EN not defined:
  - Sums wrap modulo 2^OUT_WIDTH.
  - overflow is tied to 0.

## Structure
- Shared package xeng_pkg holds:
  - W_IN and ACC_WIDTH functions.
  - N_STOKES.
  - Component pack/unpack helpers shared with the tap chain.
- One sub-module, vacc_sdp_ram: simple dual-port RAM with 1-cycle registered read, one write port, width OUT_BUS, depth 2^VECTOR_LEN_BITS.

## Test plan
- Default parameters except VECTOR_LEN_BITS=2.
  - Stimulus: acc_len=3, sync_in then 12 back-to-back words with every component = 5.
  - Required: exactly 4 dout words, all components 15, dout_sync on the first; first dout_valid 3 cycles after word 8.
- acc_len=0.
  - Stimulus: 4 words with components -3.
  - Required: each is output directly as -3 (sign-extended to 0xFFFFFFFD).
- Stimulus: sync_in reasserted after 6 of 12 words, then 12 more words with value 1 and acc_len=3.
  - Required: no dump from the partial integration; the dump then has all components 3.
- Stimulus: valid_in toggling 1/0 through a full integration.
  - Required: the same dout values as the back-to-back case, each 3 cycles after its final word.
- XENG_VACC_SATURATE_EN build, OUT_WIDTH=20.
  - Stimulus: accumulate max positive W_IN inputs (131071) over 16 vectors.
  - Required: dout clamps to 524287 and overflow=1.
  - Non-saturate build, same stimulus: wrapped value and overflow=0.
- Stimulus: rst pulsed while words are in flight.
  - Required: all outputs 0 on the next edge; valid_in is ignored until the next sync_in.
